// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with a per-register busy
// scoreboard, same-cycle write-to-read forwarding and a decode hazard output.
// Multi-cycle producers mark their destination busy at issue and clear it
// on completion, so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst             core clock (rising edge), async active-low reset
//   rs1_addr/rs2_addr    source indices; rs1_use/rs2_use qualify them
//   rs1_data/rs2_data    combinational read data (forwarded when BYPASS)
//   iss_en, iss_rd       issue request and its destination
//   iss_ack, stall       issue accepted / decode must hold
//   wr_en/addr/data      writeback completion
//   pend_cnt             number of busy registers
//
// NREG must be a power of two with AW == log2(NREG).
module regfile_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_use,
  input  logic            rs2_use,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ack,
  output logic            stall,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_nxt;

  // An index that holds real state (register 0 is hardwired when ZERO_R0).
  function automatic logic eff(input logic [AW-1:0] a);
    return (ZERO_R0 == 0) || (a != '0);
  endfunction

  logic wr_eff, rs1_hit, rs2_hit, rd_hit;
  logic b1, b2, bd, set_en, clr_en;

  assign wr_eff  = wr_en && eff(wr_addr);
  assign rs1_hit = (BYPASS != 0) && wr_en && (wr_addr == rs1_addr);
  assign rs2_hit = (BYPASS != 0) && wr_en && (wr_addr == rs2_addr);
  // WAW view ignores BYPASS: the new producer writes no earlier than next cycle.
  assign rd_hit  = wr_en && (wr_addr == iss_rd);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (eff(rs1_addr)) rs1_data = rs1_hit ? wr_data : regs[rs1_addr];
    if (eff(rs2_addr)) rs2_data = rs2_hit ? wr_data : regs[rs2_addr];
  end

  assign b1      = busy[rs1_addr] && !rs1_hit;
  assign b2      = busy[rs2_addr] && !rs2_hit;
  assign bd      = busy[iss_rd]   && !rd_hit;
  assign stall   = iss_en && ((rs1_use && b1) || (rs2_use && b2) || bd);
  assign iss_ack = iss_en && !stall;

  assign set_en  = iss_ack && eff(iss_rd);
  // Only a clear of a register that was actually busy decrements the count.
  assign clr_en  = wr_eff && busy[wr_addr];

  // Set is applied after clear so a same-register issue+completion ends busy.
  // Net count change in that case is +1-1 = 0 when it was busy, +1 otherwise.
  always_comb begin
    busy_nxt = busy;
    if (wr_eff) busy_nxt[wr_addr] = 1'b0;
    if (set_en) busy_nxt[iss_rd]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_cnt + {{AW{1'b0}}, set_en} - {{AW{1'b0}}, clr_en};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two DUT instances (BYPASS=1 and BYPASS=0) share stimulus.
// The driver computes expected outputs from an array/popcount model and
// queues them; a negedge monitor pops and compares.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, iss_rd, wr_addr;
  logic        rs1_use, rs2_use, iss_en, wr_en;
  logic [31:0] wr_data;

  logic [31:0] a_rs1, a_rs2, n_rs1, n_rs2;
  logic        a_ack, a_stall, n_ack, n_stall;
  logic [5:0]  a_pc, n_pc;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1), .ZERO_R0(1)) u_byp (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_use(rs1_use), .rs2_use(rs2_use), .rs1_data(a_rs1), .rs2_data(a_rs2),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ack(a_ack), .stall(a_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_cnt(a_pc));

  regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0), .ZERO_R0(1)) u_nbyp (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_use(rs1_use), .rs2_use(rs2_use), .rs1_data(n_rs1), .rs2_data(n_rs2),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ack(n_ack), .stall(n_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_cnt(n_pc));

  typedef struct packed {
    logic [1:0][31:0] r1;
    logic [1:0][31:0] r2;
    logic [1:0]       st;
    logic [1:0]       ack;
    logic [1:0][5:0]  pc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  // Reference state, index 0 = forwarding instance, 1 = non-forwarding.
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
  endtask

  task automatic model_expect(output exp_t e);
    bit byp, b1, b2, bd;
    int cnt;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      byp = (k == 0);
      e.r1[k] = (rs1_addr == 0) ? 32'd0 :
                (byp && wr_en && wr_addr == rs1_addr) ? wr_data : m_regs[k][rs1_addr];
      e.r2[k] = (rs2_addr == 0) ? 32'd0 :
                (byp && wr_en && wr_addr == rs2_addr) ? wr_data : m_regs[k][rs2_addr];
      b1 = m_busy[k][rs1_addr] && !(byp && wr_en && wr_addr == rs1_addr);
      b2 = m_busy[k][rs2_addr] && !(byp && wr_en && wr_addr == rs2_addr);
      bd = m_busy[k][iss_rd]   && !(wr_en && wr_addr == iss_rd);
      e.st[k]  = iss_en && ((rs1_use && b1) || (rs2_use && b2) || bd);
      e.ack[k] = iss_en && !e.st[k];
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += m_busy[k][i];
      e.pc[k] = 6'(cnt);
    end
  endtask

  // One cycle: inputs already driven (just after a rising edge).
  task automatic cyc();
    exp_t e;
    if (!rst) model_clear();
    model_expect(e);
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en && wr_addr != 0) begin
          m_regs[k][wr_addr] = wr_data;
          m_busy[k][wr_addr] = 1'b0;
        end
        if (e.ack[k] && iss_rd != 0) m_busy[k][iss_rd] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    rs1_use = 0; rs2_use = 0; iss_en = 0; wr_en = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("byp.rs1_data", a_rs1, e.r1[0]);
      chk("byp.rs2_data", a_rs2, e.r2[0]);
      chk("byp.stall",    32'(a_stall), 32'(e.st[0]));
      chk("byp.iss_ack",  32'(a_ack),   32'(e.ack[0]));
      chk("byp.pend_cnt", 32'(a_pc),    32'(e.pc[0]));
      chk("nbyp.rs1_data", n_rs1, e.r1[1]);
      chk("nbyp.rs2_data", n_rs2, e.r2[1]);
      chk("nbyp.stall",    32'(n_stall), 32'(e.st[1]));
      chk("nbyp.iss_ack",  32'(n_ack),   32'(e.ack[1]));
      chk("nbyp.pend_cnt", 32'(n_pc),    32'(e.pc[1]));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; rs1_addr = 0; rs2_addr = 0; iss_rd = 0; wr_addr = 0; wr_data = 0;
    idle();
    model_clear();
    @(posedge clk); #1;

    // reset state, random read addresses
    rs1_addr = 5'd13; rs2_addr = 5'd31; iss_en = 1; iss_rd = 5'd2; cyc();
    rst = 1; idle(); cyc();

    // write/read with forwarding
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5; cyc();
    wr_en = 0; cyc();

    // x0 protection
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs1_addr = 0; rs2_addr = 0; cyc();
    wr_en = 0; cyc();
    iss_en = 1; iss_rd = 0; cyc();

    // RAW stall, then released by a same-cycle completion
    iss_en = 1; iss_rd = 7; cyc();
    iss_rd = 10; rs2_use = 1; rs2_addr = 7; cyc();
    wr_en = 1; wr_addr = 7; wr_data = 32'h55; cyc();
    idle(); cyc();

    // WAW and simultaneous set/clear
    iss_en = 1; iss_rd = 9; cyc();
    cyc();
    wr_en = 1; wr_addr = 9; wr_data = 32'hCAFE0009; cyc();
    idle(); rs1_addr = 9; cyc();

    // reset mid-flight
    iss_en = 1; iss_rd = 3; cyc();
    iss_rd = 4; cyc();
    iss_rd = 6; cyc();
    idle(); rs1_use = 1; rs1_addr = 3; rs2_addr = 5; iss_en = 1; iss_rd = 11; cyc();
    rst = 0; cyc();
    rst = 1; idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h44; cyc();
    idle(); rs1_addr = 4; cyc();

    // randomized traffic on a narrow index range to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      rst      = ($urandom_range(199) != 0);
      rs1_addr = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
      rs2_addr = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
      iss_rd   = 5'($urandom_range(7));
      wr_addr  = 5'($urandom_range(7));
      rs1_use  = 1'($urandom);
      rs2_use  = 1'($urandom);
      iss_en   = 1'($urandom);
      wr_en    = 1'($urandom);
      wr_data  = $urandom;
      cyc();
    end

    rst = 1; idle(); cyc();
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RV32I core, with configurable data width and register count.
- Adds a per-register busy scoreboard, same-cycle write-to-read bypass, and a hazard/stall output.
- Lets multi-cycle producers (loads, future mul/div) issue and complete out of step with the decode stage.
- Sits between decode and writeback: decode supplies source/destination indices, writeback supplies completions.

Parameters:
- XLEN, 32, data width of every register and data port.
- NREG, 32, number of architectural registers; power of two, ≥ 2.
- AW, 5, index width; must equal log2(NREG).
- BYPASS, 1, 1 = a write in the same cycle is forwarded to matching read ports and busy outputs; 0 = no forwarding.
- ZERO_R0, 1, 1 = register 0 reads as 0, ignores writes and is never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  read port 1 index.
- rs2_addr  in  AW  read port 2 index.
- rs1_use  in  1  instruction in decode reads rs1.
- rs2_use  in  1  instruction in decode reads rs2.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- iss_en  in  1  decode requests issue of an instruction that writes iss_rd.
- iss_rd  in  AW  destination of the issuing instruction.
- iss_ack  out  1  issue accepted this cycle.
- stall  out  1  hazard: decode must hold.
- wr_en  in  1  writeback completion.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- pend_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (rst low, asynchronous):
  - All registers and all busy bits clear; pend_cnt = 0.
  - Combinational outputs follow from the cleared state: rs*_data = 0, stall = 0, iss_ack = iss_en.
  - Reset asserted mid-operation discards every pending busy bit; completions arriving after reset still write data normally.
- Register 0 handling (ZERO_R0 = 1): "eff" means an index that is not 0.
  - Writes to 0 are dropped.
  - Reads of 0 return 0.
  - busy[0] is never set; issuing to 0 is a legal no-op and sets no busy bit.
- Write (registered):
  - On a rising edge with wr_en and eff wr_addr, regs[wr_addr] <= wr_data and busy[wr_addr] is cleared.
  - A completion to a non-busy register is legal: data is written, busy stays 0.
- Read (combinational, zero latency):
  - rsN_data = regs[rsN_addr].
  - If BYPASS and wr_en and wr_addr == rsN_addr and the index is eff, rsN_data = wr_data instead.
- Busy view, per source (b1, b2):
  - bN = busy[rsN_addr].
  - If BYPASS and wr_en and wr_addr == rsN_addr, bN = 0, because data is forwarded this cycle.
- WAW view, bd:
  - bd = busy[iss_rd], cleared by a matching wr_en regardless of BYPASS.
  - This is safe because the issued producer writes no earlier than the next cycle.
- Hazard and issue:
  - stall = iss_en & ((rs1_use & b1) | (rs2_use & b2) | bd).
  - iss_ack = iss_en & !stall.
  - On a rising edge with iss_ack and eff iss_rd, busy[iss_rd] is set.
- Simultaneous issue and completion to the same eff register in one cycle:
  - The data write occurs.
  - busy ends SET: the set from the new producer wins over the clear.
- pend_cnt is a registered counter, +1 per set, −1 per clear; net 0 when both hit different registers.
  - It never exceeds NREG (NREG−1 when ZERO_R0 = 1) and never underflows.
  - A clear of a non-busy register does not decrement.
- There are no other sequential elements.
- Every combinational output depends only on current inputs and registered state; no outputs are registered beyond regs, busy and pend_cnt.

Test Plan:
- Reset then reads: rst low, then high. Any rs1_addr/rs2_addr gives data 0; pend_cnt = 0; stall = 0.
- Write/read with bypass (BYPASS = 1): wr_en, wr_addr = 5, wr_data = 0xDEADBEEF, rs1_addr = 5.
  - Same cycle: rs1_data = 0xDEADBEEF.
  - Next cycle with wr_en = 0: still 0xDEADBEEF.
  - Repeat with BYPASS = 0: same cycle shows the old value 0, next cycle 0xDEADBEEF.
- x0 protection: write 0x1234 to addr 0, then read 0 → 0. Issue to rd 0 → iss_ack = 1, pend_cnt stays 0.
- RAW stall:
  - Issue rd = 7; next cycle issue with rs2_use and rs2_addr = 7 → stall = 1, iss_ack = 0, pend_cnt = 1.
  - Complete wr_addr = 7, wr_data = 0x55 in the same cycle → stall = 0, rs2_data = 0x55 (BYPASS = 1).
- WAW and simultaneous set/clear:
  - Busy rd = 9; issue rd = 9 alone → stall = 1.
  - Issue rd = 9 with wr_en to 9 in the same cycle → iss_ack = 1; after the edge busy[9] = 1, pend_cnt unchanged at 1, regs[9] = new data.
- Reset mid-flight: busy regs 3, 4, 6 (pend_cnt = 3) → assert rst asynchronously between edges. pend_cnt = 0 immediately, all stalls drop, regs read 0.
